pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/pc_sequencer_if.sv | 29 ++
 rtl/sat_counter.sv | 28 ++
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: reset vector, PC sequencer states,
// next-PC select encodings and a word-alignment helper.
package cpu_pkg;

    localparam int unsigned ADDR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000;

    // Sequencer states: normal fetch, or waiting one advance to commit a
    // redirect that was taken ahead of a delay slot.
    typedef enum logic {
        RUN     = 1'b0,
        DS_WAIT = 1'b1
    } seq_state_e;

    // Next-PC source selection.
    typedef enum logic [1:0] {
        NPC_SEQ    = 2'b00,
        NPC_JIDX   = 2'b01,
        NPC_BRANCH = 2'b10,
        NPC_REG    = 2'b11
    } npc_sel_e;

    // Taken targets are always forced onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-transfer request bus into the PC sequencer.
//   stall       : hazard hold, nothing advances while high
//   ctrl_valid  : a control-transfer decision is presented
//   ctrl_taken  : the presented transfer is taken
//   ctrl_target : target address for a taken transfer
// master = decision producer, slave = pc_sequencer.
interface pc_sequencer_if;
    import cpu_pkg::*;

    logic              stall;
    logic              ctrl_valid;
    logic              ctrl_taken;
    logic [ADDR_W-1:0] ctrl_target;

    modport master (
        output stall,
        output ctrl_valid,
        output ctrl_taken,
        output ctrl_target
    );

    modport slave (
        input stall,
        input ctrl_valid,
        input ctrl_taken,
        input ctrl_target
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : clock
//   clear : synchronous clear, dominates inc
//   inc   : add one unless already all-ones
//   count : current count
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    // Count register; holds at all-ones once saturated.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with optional branch delay slot.
// Build option: define DELAY_SLOT_EN to execute one delay-slot instruction
// before a taken redirect commits; otherwise taken redirects are immediate
// and flush the sequentially fetched instruction.
//   clk          : clock, all state updates on the rising edge
//   reset        : synchronous active-high reset
//   ctrl         : stall / control-transfer request bus (slave side)
//   pc           : current fetch address (registered)
//   pc_plus4     : pc + 4 (combinational)
//   flush        : kill the sequential fetch (combinational)
//   ds_pending   : a delay-slot redirect is waiting
//   misalign_err : sticky, a taken target had nonzero low bits
//   redirect_cnt : saturating count of committed taken redirects
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    pc_sequencer_if.slave     ctrl,
    output logic [31:0]       pc,
    output logic [31:0]       pc_plus4,
    output logic              flush,
    output logic              ds_pending,
    output logic              misalign_err,
    output logic [CNT_W-1:0]  redirect_cnt
);
    import cpu_pkg::*;

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] seq_pc;
    npc_sel_e          npc_sel;
    logic              pc_en;
    logic              cnt_inc;
    logic              taken;

    assign seq_pc = pc_q + 32'd4;
    assign taken  = ctrl.ctrl_valid && ctrl.ctrl_taken;

    // State and architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            target_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            misalign_q <= misalign_d;
            if (pc_en) begin
                pc_q <= pc_d;
            end
        end
    end

    // Next-state, next-PC select, redirect commit and flush.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        misalign_d = misalign_q;
        npc_sel    = NPC_SEQ;
        pc_en      = 1'b0;
        cnt_inc    = 1'b0;
        flush      = 1'b0;
        if (!reset && !ctrl.stall) begin
            pc_en = 1'b1;
            case (state_q)
                RUN: begin
                    if (taken) begin
                        if (ctrl.ctrl_target[1:0] != 2'b00) begin
                            misalign_d = 1'b1;
                        end
`ifdef DELAY_SLOT_EN
                        // Fetch the delay slot now, redirect on the next advance.
                        target_d = align_word(ctrl.ctrl_target);
                        state_d  = DS_WAIT;
`else
                        npc_sel = NPC_BRANCH;
                        flush   = 1'b1;
                        cnt_inc = 1'b1;
`endif
                    end
                end
                DS_WAIT: begin
                    // Any decision presented in the delay slot is ignored.
                    npc_sel = NPC_REG;
                    state_d = RUN;
                    cnt_inc = 1'b1;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Next-PC mux.
    always_comb begin
        case (npc_sel)
            NPC_SEQ:    pc_d = seq_pc;
            NPC_BRANCH: pc_d = align_word(ctrl.ctrl_target);
            NPC_REG:    pc_d = target_q;
            default:    pc_d = seq_pc;
        endcase
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (cnt_inc),
        .count (redirect_cnt)
    );

    assign pc           = pc_q;
    assign pc_plus4     = seq_pc;
    assign ds_pending   = (state_q == DS_WAIT);
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

`ifdef DELAY_SLOT_EN
    localparam bit DS_MODE = 1'b1;
`else
    localparam bit DS_MODE = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] pc, pc_plus4, pc_s, pc_plus4_s;
    logic        flush, ds_pending, misalign_err;
    logic        flush_s, ds_pending_s, misalign_err_s;
    logic [15:0] redirect_cnt;
    logic [1:0]  redirect_cnt_s;

    pc_sequencer_if bus ();
    pc_sequencer_if bus_s ();

    pc_sequencer #(.CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .ctrl         (bus.slave),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .flush        (flush),
        .ds_pending   (ds_pending),
        .misalign_err (misalign_err),
        .redirect_cnt (redirect_cnt)
    );

    pc_sequencer #(.CNT_W(2)) dut_s (
        .clk          (clk),
        .reset        (reset),
        .ctrl         (bus_s.slave),
        .pc           (pc_s),
        .pc_plus4     (pc_plus4_s),
        .flush        (flush_s),
        .ds_pending   (ds_pending_s),
        .misalign_err (misalign_err_s),
        .redirect_cnt (redirect_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural PC, queue of redirects awaiting commit,
    // redirect totals saturated at each counter's maximum.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_q[$];
    int          m_cnt = 0;
    int          m_cnt_s = 0;
    bit          m_mis = 1'b0;

    function automatic int sat_add(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    task automatic model_step(input bit rst, st, v, tk, input logic [31:0] tgt);
        if (rst) begin
            m_pc = 32'h0000_3000;
            m_q.delete();
            m_cnt = 0;
            m_cnt_s = 0;
            m_mis = 1'b0;
        end else if (!st) begin
            if (m_q.size() != 0) begin
                m_pc = m_q.pop_front();
                m_cnt = sat_add(m_cnt, 65535);
                m_cnt_s = sat_add(m_cnt_s, 3);
            end else if (v && tk) begin
                if (tgt[1:0] != 2'b00) m_mis = 1'b1;
                if (DS_MODE) begin
                    m_q.push_back(tgt & 32'hFFFF_FFFC);
                    m_pc = m_pc + 32'd4;
                end else begin
                    m_pc = tgt & 32'hFFFF_FFFC;
                    m_cnt = sat_add(m_cnt, 65535);
                    m_cnt_s = sat_add(m_cnt_s, 3);
                end
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    // One cycle: drive, check flush before the edge, step model, check state after.
    task automatic apply(input bit rst, st, v, tk, input logic [31:0] tgt, output bit fl);
        bit exp_fl;
        @(negedge clk);
        reset = rst;
        bus.stall = st;   bus.ctrl_valid = v;   bus.ctrl_taken = tk;   bus.ctrl_target = tgt;
        bus_s.stall = st; bus_s.ctrl_valid = v; bus_s.ctrl_taken = tk; bus_s.ctrl_target = tgt;
        #1;
        exp_fl = !rst && !st && (m_q.size() == 0) && v && tk && !DS_MODE;
        fl = flush;
        chk("flush", 32'(flush), 32'(exp_fl));
        chk("flush_s", 32'(flush_s), 32'(exp_fl));
        @(posedge clk);
        model_step(rst, st, v, tk, tgt);
        #1;
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("ds_pending", 32'(ds_pending), 32'(m_q.size() != 0));
        chk("misalign", 32'(misalign_err), 32'(m_mis));
        chk("cnt", 32'(redirect_cnt), 32'(m_cnt));
        chk("pc_s", pc_s, m_pc);
        chk("cnt_s", 32'(redirect_cnt_s), 32'(m_cnt_s));
    endtask

    typedef struct {
        bit          rst, st, v, tk;
        logic [31:0] tgt;
        bit          e_fl;
        logic [31:0] e_pc;
        bit          e_ds, e_mis;
        int          e_cnt;
    } vec_t;

    function automatic vec_t mk(input bit rst, st, v, tk, input logic [31:0] tgt,
                                input bit fl, input logic [31:0] epc,
                                input bit ds, mis, input int cnt);
        vec_t r;
        r.rst = rst; r.st = st; r.v = v; r.tk = tk; r.tgt = tgt;
        r.e_fl = fl; r.e_pc = epc; r.e_ds = ds; r.e_mis = mis; r.e_cnt = cnt;
        return r;
    endfunction

    vec_t tbl[21];

    initial begin
        bit fl;
        reset = 1'b1;
        bus.stall = 1'b0;   bus.ctrl_valid = 1'b0;   bus.ctrl_taken = 1'b0;   bus.ctrl_target = '0;
        bus_s.stall = 1'b0; bus_s.ctrl_valid = 1'b0; bus_s.ctrl_taken = 1'b0; bus_s.ctrl_target = '0;

`ifdef DELAY_SLOT_EN
        tbl[0]  = mk(1,0,0,0,32'h0,         0,32'h3000,0,0,0);
        tbl[1]  = mk(0,0,0,0,32'h0,         0,32'h3004,0,0,0);
        tbl[2]  = mk(0,0,0,0,32'h0,         0,32'h3008,0,0,0);
        tbl[3]  = mk(0,0,0,0,32'h0,         0,32'h300C,0,0,0);
        tbl[4]  = mk(1,0,0,0,32'h0,         0,32'h3000,0,0,0);
        tbl[5]  = mk(0,0,0,0,32'h0,         0,32'h3004,0,0,0);
        tbl[6]  = mk(0,0,1,1,32'h3100,      0,32'h3008,1,0,0);
        tbl[7]  = mk(0,0,0,0,32'h0,         0,32'h3100,0,0,1);
        tbl[8]  = mk(0,0,1,1,32'h3200,      0,32'h3104,1,0,1);
        tbl[9]  = mk(0,1,1,1,32'h4000,      0,32'h3104,1,0,1);
        tbl[10] = mk(0,1,1,1,32'h4000,      0,32'h3104,1,0,1);
        tbl[11] = mk(0,0,0,0,32'h0,         0,32'h3200,0,0,2);
        tbl[12] = mk(0,0,1,1,32'h3102,      0,32'h3204,1,1,2);
        tbl[13] = mk(0,0,0,0,32'h0,         0,32'h3100,0,1,3);
        tbl[14] = mk(0,0,1,1,32'h3300,      0,32'h3104,1,1,3);
        tbl[15] = mk(1,0,1,1,32'h3500,      0,32'h3000,0,0,0);
        tbl[16] = mk(0,0,0,0,32'h0,         0,32'h3004,0,0,0);
        tbl[17] = mk(0,0,1,1,32'hFFFF_FFFC, 0,32'h3008,1,0,0);
        tbl[18] = mk(0,0,0,0,32'h0,         0,32'hFFFF_FFFC,0,0,1);
        tbl[19] = mk(0,0,0,0,32'h0,         0,32'h0,0,0,1);
        tbl[20] = mk(0,1,1,1,32'h5000,      0,32'h0,0,0,1);
`else
        tbl[0]  = mk(1,0,0,0,32'h0,         0,32'h3000,0,0,0);
        tbl[1]  = mk(0,0,0,0,32'h0,         0,32'h3004,0,0,0);
        tbl[2]  = mk(0,0,0,0,32'h0,         0,32'h3008,0,0,0);
        tbl[3]  = mk(0,0,0,0,32'h0,         0,32'h300C,0,0,0);
        tbl[4]  = mk(1,0,0,0,32'h0,         0,32'h3000,0,0,0);
        tbl[5]  = mk(0,0,0,0,32'h0,         0,32'h3004,0,0,0);
        tbl[6]  = mk(0,0,1,1,32'h3100,      1,32'h3100,0,0,1);
        tbl[7]  = mk(0,0,0,0,32'h0,         0,32'h3104,0,0,1);
        tbl[8]  = mk(0,0,1,1,32'h3200,      1,32'h3200,0,0,2);
        tbl[9]  = mk(0,1,1,1,32'h4000,      0,32'h3200,0,0,2);
        tbl[10] = mk(0,1,1,1,32'h4000,      0,32'h3200,0,0,2);
        tbl[11] = mk(0,0,0,0,32'h0,         0,32'h3204,0,0,2);
        tbl[12] = mk(0,0,1,1,32'h3102,      1,32'h3100,0,1,3);
        tbl[13] = mk(0,0,0,0,32'h0,         0,32'h3104,0,1,3);
        tbl[14] = mk(0,0,1,1,32'h3300,      1,32'h3300,0,1,4);
        tbl[15] = mk(1,0,1,1,32'h3500,      0,32'h3000,0,0,0);
        tbl[16] = mk(0,0,0,0,32'h0,         0,32'h3004,0,0,0);
        tbl[17] = mk(0,0,1,1,32'hFFFF_FFFC, 1,32'hFFFF_FFFC,0,0,1);
        tbl[18] = mk(0,0,0,0,32'h0,         0,32'h0,0,0,1);
        tbl[19] = mk(0,0,0,0,32'h0,         0,32'h4,0,0,1);
        tbl[20] = mk(0,1,1,1,32'h5000,      0,32'h4,0,0,1);
`endif

        // Directed table against hand-derived expectations.
        for (int i = 0; i < 21; i++) begin
            apply(tbl[i].rst, tbl[i].st, tbl[i].v, tbl[i].tk, tbl[i].tgt, fl);
            chk($sformatf("tbl%0d_flush", i), 32'(fl), 32'(tbl[i].e_fl));
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("tbl%0d_ds", i), 32'(ds_pending), 32'(tbl[i].e_ds));
            chk($sformatf("tbl%0d_mis", i), 32'(misalign_err), 32'(tbl[i].e_mis));
            chk($sformatf("tbl%0d_cnt", i), 32'(redirect_cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_cnt_s", i), 32'(redirect_cnt_s),
                32'((tbl[i].e_cnt > 3) ? 3 : tbl[i].e_cnt));
        end

        // Five committed redirects: narrow counter saturates at 3.
        apply(1, 0, 0, 0, 32'h0, fl);
        for (int k = 0; k < 5; k++) begin
            apply(0, 0, 1, 1, 32'h0000_3000 + 32'(k * 64), fl);
            apply(0, 0, 0, 0, 32'h0, fl);
        end
        chk("sat_cnt_s", 32'(redirect_cnt_s), 32'd3);
        chk("sat_cnt", 32'(redirect_cnt), 32'd5);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            bit          r_rst, r_st, r_v, r_tk;
            logic [31:0] r_tgt;
            r_rst = ($urandom_range(0, 63) == 0);
            r_st  = ($urandom_range(0, 3) == 0);
            r_v   = ($urandom_range(0, 1) == 1);
            r_tk  = ($urandom_range(0, 1) == 1);
            r_tgt = $urandom;
            if ($urandom_range(0, 3) != 0) r_tgt[1:0] = 2'b00;
            apply(r_rst, r_st, r_v, r_tk, r_tgt, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
